dmem_arbiter: RTL and testbench

Shares the byte-wide, single-port data memory between two word-wide requesters: the processor's load/store path (`cpu_*`) and the memory loader/debug port (`ldr_*`). Each 32-bit word access is serialized into four byte accesses, big-endian, matching the processor's existing byte order: the byte at `addr` is `[31:24]` and the byte at `addr+3` is `[7:0]`. The block sits between the processor datapath and the data memory. It stalls the processor while a CPU access is pending.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_rr_pick.sv | 22 ++
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the byte-serialized data memory arbiter.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        RWAIT = 2'd2,
        DONE  = 2'd3
    } dmem_state_t;

    localparam logic GRANT_CPU      = 1'b0;
    localparam logic GRANT_LDR      = 1'b1;
    localparam int   BYTES_PER_WORD = 4;

    // Big-endian byte select: idx 0 is [31:24], idx 3 is [7:0].
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [31:0] sh;
        sh = w << {idx, 3'b000};
        return sh[31:24];
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports (CPU, loader), byte memory port and status of the data memory arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 5
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_done;
    logic              cpu_stall;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [31:0]       ldr_wdata;
    logic [31:0]       ldr_rdata;
    logic              ldr_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    logic              busy;
    logic              grant;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_done, cpu_stall,
        output ldr_rdata, ldr_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, grant
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_done, cpu_stall,
        input  ldr_rdata, ldr_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, grant
    );

endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way requester picker: round-robin on a tie when FAIR, otherwise loader priority.
// Purely combinational; req_i[0] is the CPU, req_i[1] the loader.
module dmem_rr_pick
    import dmem_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       winner_o
);

    always_comb begin
        winner_o = GRANT_CPU;
        if (req_i == 2'b11) begin
            winner_o = FAIR ? ~last_grant_i : GRANT_LDR;
        end else if (req_i[1]) begin
            winner_o = GRANT_LDR;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serializes CPU/loader word accesses into four big-endian byte accesses on a shared byte memory.
// Write done 5 cycles after the request is sampled, read done 6 cycles after; requesters hold req until done.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter bit FAIR   = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    dmem_arbiter_if.slave bus
);

    dmem_state_t       state_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic              grant_q;
    logic              last_grant_q;
    logic [31:0]       asm_q;
    logic [31:0]       rd_word_d;
    logic [31:0]       cpu_rdata_q;
    logic [31:0]       ldr_rdata_q;
    logic              cpu_done_q;
    logic              ldr_done_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;

    logic              winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;

    dmem_rr_pick #(
        .FAIR (FAIR)
    ) u_pick (
        .req_i        ({bus.ldr_req, bus.cpu_req}),
        .last_grant_i (last_grant_q),
        .winner_o     (winner)
    );

    always_comb begin
        sel_we    = bus.cpu_we;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        if (winner == GRANT_LDR) begin
            sel_we    = bus.ldr_we;
            sel_addr  = bus.ldr_addr;
            sel_wdata = bus.ldr_wdata;
        end
    end

    assign cnt_d     = cnt_q + 2'd1;
    // The last read byte is still on mem_rdata when RWAIT completes the word.
    assign rd_word_d = {asm_q[23:0], bus.mem_rdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            we_q         <= 1'b0;
            base_q       <= '0;
            wdata_q      <= 32'd0;
            grant_q      <= GRANT_CPU;
            last_grant_q <= GRANT_LDR;
            asm_q        <= 32'd0;
            cpu_rdata_q  <= 32'd0;
            ldr_rdata_q  <= 32'd0;
            cpu_done_q   <= 1'b0;
            ldr_done_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'd0;
        end else begin
            cpu_done_q <= 1'b0;
            ldr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= 2'd0;
                    if (bus.cpu_req || bus.ldr_req) begin
                        grant_q      <= winner;
                        last_grant_q <= winner;
                        we_q         <= sel_we;
                        base_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                        // Byte 0 goes out on the first XFER cycle.
                        mem_en_q     <= 1'b1;
                        mem_we_q     <= sel_we;
                        mem_addr_q   <= sel_addr;
                        mem_wdata_q  <= word_byte(sel_wdata, 2'd0);
                        state_q      <= XFER;
                    end
                end
                XFER: begin
                    if (!we_q && cnt_q != 2'd0) begin
                        asm_q <= rd_word_d;
                    end
                    cnt_q <= cnt_d;
                    if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (we_q) begin
                            cpu_done_q <= (grant_q == GRANT_CPU);
                            ldr_done_q <= (grant_q == GRANT_LDR);
                            state_q    <= DONE;
                        end else begin
                            state_q <= RWAIT;
                        end
                    end else begin
                        mem_addr_q  <= base_q + ADDR_W'(cnt_d);
                        mem_wdata_q <= word_byte(wdata_q, cnt_d);
                    end
                end
                RWAIT: begin
                    asm_q <= rd_word_d;
                    if (grant_q == GRANT_LDR) begin
                        ldr_rdata_q <= rd_word_d;
                        ldr_done_q  <= 1'b1;
                    end else begin
                        cpu_rdata_q <= rd_word_d;
                        cpu_done_q  <= 1'b1;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_done_q;
    assign bus.ldr_rdata = ldr_rdata_q;
    assign bus.ldr_done  = ldr_done_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.grant     = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte-write scoreboard, table of single transfers,
// hand sequences for contention (FAIR=1 and FAIR=0) and reset during a write.
module tb_dmem_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(5)) bus ();
    dmem_arbiter_if #(.ADDR_W(5)) bus0 ();

    dmem_arbiter #(.ADDR_W(5), .FAIR(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    dmem_arbiter #(.ADDR_W(5), .FAIR(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [4:0] a;
        logic [7:0] d;
    } wb_t;
    wb_t wq[$];
    wb_t mon_e;

    typedef struct packed {
        bit         port;
        bit         we;
        logic [4:0] a;
        logic [31:0] wd;
        logic [31:0] ev;
    } vec_t;
    vec_t vecs [8];

    logic [31:0] exp_rd [2];
    logic [7:0]  mem1 [32];

    // Byte memory behind the FAIR=1 instance: synchronous read, write on enable.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem1[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata      <= mem1[bus.mem_addr];
        end
    end
    assign bus0.mem_rdata = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ev);
        n_total++;
        if (act === ev) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, ev);
    endtask

    task automatic push_word(input logic [4:0] a, input logic [31:0] w, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            wb_t e;
            e.a = a + 5'(i);
            e.d = w[31-8*i -: 8];
            wq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            if (wq.size() == 0) begin
                chk("wr_unexpected", 32'(bus.mem_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = wq.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(mon_e.a));
                chk("wr_data", 32'(bus.mem_wdata), 32'(mon_e.d));
            end
        end
    end

    task automatic drv(input bit on_fair, input bit port, input bit req, input bit we,
                       input logic [4:0] a, input logic [31:0] wd);
        if (on_fair) begin
            if (port) begin bus.ldr_req = req; bus.ldr_we = we; bus.ldr_addr = a; bus.ldr_wdata = wd; end
            else      begin bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd; end
        end else begin
            if (port) begin bus0.ldr_req = req; bus0.ldr_we = we; bus0.ldr_addr = a; bus0.ldr_wdata = wd; end
            else      begin bus0.cpu_req = req; bus0.cpu_we = we; bus0.cpu_addr = a; bus0.cpu_wdata = wd; end
        end
    endtask

    // One word transfer on the FAIR=1 instance; n counts cycles from the sampling cycle.
    task automatic do_xfer(input bit port, input bit we, input logic [4:0] a,
                           input logic [31:0] wd, input logic [31:0] ev);
        int n;
        int lat;
        bit got;
        bit dn;
        bit stall_ok;
        bit busy_ok;
        @(posedge clk); #1;
        drv(1'b1, port, 1'b1, we, a, wd);
        if (we) push_word(a, wd, 4);
        lat = we ? 5 : 6;
        n = 0; got = 0; stall_ok = 1; busy_ok = 1;
        while (!got && n < 12) begin
            @(negedge clk);
            dn = port ? bus.ldr_done : bus.cpu_done;
            if (bus.busy !== (n != 0)) busy_ok = 0;
            if (port == 1'b0 && bus.cpu_stall !== !dn) stall_ok = 0;
            if (dn) begin
                got = 1;
                chk("xfer_latency", n, lat);
                chk("xfer_grant", 32'(bus.grant), 32'(port));
                if (!we) exp_rd[port] = ev;
                chk("xfer_cpu_rdata", bus.cpu_rdata, exp_rd[0]);
                chk("xfer_ldr_rdata", bus.ldr_rdata, exp_rd[1]);
            end else begin
                n++;
            end
        end
        chk("xfer_done_seen", 32'(got), 32'd1);
        chk("xfer_busy", 32'(busy_ok), 32'd1);
        if (port == 1'b0) chk("xfer_cpu_stall", 32'(stall_ok), 32'd1);
        @(posedge clk); #1;
        drv(1'b1, port, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    // Both ports hold write requests; who[k] is the expected owner of the k-th completion.
    task automatic contend(input bit on_fair, input bit [2:0] who);
        int k;
        int n;
        bit cd;
        bit ld;
        @(posedge clk); #1;
        drv(on_fair, 1'b0, 1'b1, 1'b1, 5'd8,  32'h01020304);
        drv(on_fair, 1'b1, 1'b1, 1'b1, 5'd12, 32'h0A0B0C0D);
        if (on_fair) begin
            for (int j = 0; j < 3; j++) begin
                if (who[j]) push_word(5'd12, 32'h0A0B0C0D, 4);
                else        push_word(5'd8,  32'h01020304, 4);
            end
        end
        k = 0; n = 0;
        while (k < 3 && n < 40) begin
            @(negedge clk);
            cd = on_fair ? bus.cpu_done : bus0.cpu_done;
            ld = on_fair ? bus.ldr_done : bus0.ldr_done;
            if (cd || ld) begin
                chk(on_fair ? "ctn_fair_who" : "ctn_prio_who", 32'(ld), 32'(who[k]));
                chk(on_fair ? "ctn_fair_cycle" : "ctn_prio_cycle", n, 5 + 6 * k);
                k++;
            end
            n++;
        end
        chk("ctn_count", k, 3);
        @(posedge clk); #1;
        drv(on_fair, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        drv(on_fair, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 5'd4,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 5'd4,  32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 5'd30, 32'h11223344, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 5'd30, 32'h0,        32'h11223344};
        vecs[4] = '{1'b1, 1'b0, 5'd4,  32'h0,        32'hDEADBEEF};
        vecs[5] = '{1'b0, 1'b1, 5'd1,  32'hA5B6C7D8, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 5'd2,  32'h0,        32'hB6C7D8AD};
        vecs[7] = '{1'b1, 1'b1, 5'd16, 32'h55667788, 32'h0};
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
        drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        drv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", 32'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy,
                              bus.grant, bus.cpu_done, bus.ldr_done, bus.cpu_stall}), 32'd0);
        chk("reset_cpu_rdata", bus.cpu_rdata, 32'd0);
        chk("reset_ldr_rdata", bus.ldr_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        contend(1'b1, 3'b010);
        contend(1'b0, 3'b111);

        for (int i = 0; i < 8; i++) begin
            do_xfer(vecs[i].port, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].ev);
        end

        // Reset after two bytes of a write have been issued.
        @(posedge clk); #1;
        drv(1'b1, 1'b0, 1'b1, 1'b1, 5'd16, 32'hCAFEF00D);
        push_word(5'd16, 32'hCAFEF00D, 2);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
        chk("rst_mid_ctl", 32'({bus.mem_en, bus.mem_we, bus.busy, bus.cpu_done, bus.grant}), 32'd0);
        chk("rst_mid_bus", 32'({bus.mem_addr, bus.mem_wdata}), 32'd0);
        chk("rst_mid_cpu_rdata", bus.cpu_rdata, exp_rd[0]);
        chk("rst_mid_ldr_rdata", bus.ldr_rdata, exp_rd[1]);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_xfer(1'b0, 1'b0, 5'd16, 32'd0, 32'hCAFE7788);
        do_xfer(1'b1, 1'b0, 5'd8,  32'd0, 32'h01020304);

        repeat (2) @(posedge clk);
        chk("wr_queue_empty", wq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
